ama_appr4_acc: RTL and testbench

Streaming accumulator built around the AMA approximation-4 mirror-adder cell (Cout = A, SUM = Cin·(¬A + B)). It sits directly downstream of the cell-level adder library in the 24-bit / 6-approximate-bit datapath. It consumes a packet of operand beats and sums them with a hybrid adder: approximation-4 cells in the low `APPR_BITS` positions and an exact ripple carry above them. It returns one result per packet over a valid/ready handshake.

---
 rtl/ama_appr4_acc.sv | 133 +++++++++++++
 tb/tb_ama_appr4_acc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ama_appr4_acc.sv
// rtl/ama_appr4_acc.sv - packet accumulator on a hybrid AMA approximation-4 / exact ripple adder.
// Optional exact-adder error monitor: define AMA_ERR_MON_EN.
module ama_appr4_acc #(
    parameter int WIDTH     = 24,
    parameter int APPR_BITS = 6,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic              r_cout;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;

    logic [WIDTH-1:0]  w_hyb_sum;
    logic              w_hyb_cout;
    logic              w_accept;

    // Low cells pass A straight through as the carry; upper bits ripple exactly.
    always_comb begin
        logic c;
        c          = 1'b0;
        w_hyb_sum  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < APPR_BITS) begin
                w_hyb_sum[i] = c & (~r_acc[i] | in_data[i]);
                c            = r_acc[i];
            end else begin
                w_hyb_sum[i] = r_acc[i] ^ in_data[i] ^ c;
                c            = (r_acc[i] & in_data[i]) | (c & (r_acc[i] ^ in_data[i]));
            end
        end
        w_hyb_cout = c;
    end

    assign in_ready  = (r_state != S_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_cout  = r_cout;
    assign out_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc       <= in_data;
                        r_cout      <= 1'b0;
                        r_count     <= CNT_W'(1);
                        r_state     <= in_last ? S_HOLD : S_ACC;
                        r_out_valid <= in_last;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc  <= w_hyb_sum;
                        r_cout <= r_cout | w_hyb_cout;
                        if (r_count != {CNT_W{1'b1}})
                            r_count <= r_count + CNT_W'(1);
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_cout      <= 1'b0;
                        r_count     <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AMA_ERR_MON_EN
    logic [WIDTH:0]   w_exact;
    logic             w_err;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_exact = {1'b0, r_acc} + {1'b0, in_data};
    assign w_err   = (w_exact[WIDTH-1:0] != w_hyb_sum) || (w_exact[WIDTH] != w_hyb_cout);

    // Survives clr on purpose: it is a long-run quality statistic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if (!clr && (r_state == S_ACC) && w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}}))
            r_err_cnt <= r_err_cnt + CNT_W'(1);
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ama_appr4_acc.sv
// tb/tb_ama_appr4_acc.sv - directed checks of ama_appr4_acc (APPR_BITS=6 and APPR_BITS=0 instances).
module tb_ama_appr4_acc;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, out_ready, sel;
    logic [23:0] in_data;

    logic        rdy0, vld0, cout0, rdy1, vld1, cout1;
    logic [23:0] sum0, sum1;
    logic [15:0] cnt0, err0, cnt1, err1;
    logic        v0, v1;

    int n_total = 0;
    int n_bad   = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    assign v0 = in_valid & ~sel;
    assign v1 = in_valid & sel;

    ama_appr4_acc #(.WIDTH(24), .APPR_BITS(6), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v0), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
        .out_sum(sum0), .out_cout(cout0), .out_count(cnt0), .err_cnt(err0)
    );

    ama_appr4_acc #(.WIDTH(24), .APPR_BITS(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v1), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
        .out_sum(sum1), .out_cout(cout1), .out_count(cnt1), .err_cnt(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [23:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 20; k++) begin
            if ((sel ? rdy1 : rdy0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("beat_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if ((sel ? vld1 : vld0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("result_timeout", 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready", rdy0, 1);
        check("rst_out_valid", vld0, 0);
        check("rst_out_sum", sum0, 0);
        check("rst_out_cout", cout0, 0);
        check("rst_out_count", cnt0, 0);
        check("rst_err_cnt", err0, 0);

        // 0x3F + 0x01: approximate chain happens to match exact
        send_beat(24'h00003F, 1'b0);
        send_beat(24'h000001, 1'b1);
        wait_result();
        check("p1_sum", sum0, 32'h40);
        check("p1_count", cnt0, 2);
        check("p1_cout", cout0, 0);
        check("p1_err", err0, exp_err);
        handshake();
        check("p1_idle_valid", vld0, 0);

        // 0x10 + 0x01: approximate gives 0x20, exact 0x11
        send_beat(24'h000010, 1'b0);
        send_beat(24'h000001, 1'b1);
        wait_result();
        check("p2_sum", sum0, 32'h20);
`ifdef AMA_ERR_MON_EN
        exp_err = 1;
`endif
        check("p2_err", err0, exp_err);
        handshake();

        // fully exact instance: wraps and sets cout
        sel = 1'b1;
        send_beat(24'hFFFFFF, 1'b0);
        send_beat(24'h000002, 1'b1);
        wait_result();
        check("p3_sum", sum1, 32'h1);
        check("p3_cout", cout1, 1);
        check("p3_count", cnt1, 2);
        handshake();
        sel = 1'b0;

        // single-beat packet held under backpressure
        send_beat(24'h123456, 1'b1);
        check("p4_valid", vld0, 1);
        check("p4_sum", sum0, 32'h123456);
        check("p4_count", cnt0, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("p4_hold_valid", vld0, 1);
            check("p4_hold_sum", sum0, 32'h123456);
            check("p4_hold_ready", rdy0, 0);
        end
        out_ready = 1'b1;
        check("p4_hs_ready", rdy0, 0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("p4_after_valid", vld0, 0);
        check("p4_after_ready", rdy0, 1);
        check("p4_after_count", cnt0, 0);
        check("p4_after_sum", sum0, 0);

        // clr together with the last beat discards the packet
        send_beat(24'h000005, 1'b0);
        send_beat(24'h000007, 1'b0);
        in_valid = 1'b1; in_data = 24'h000009; in_last = 1'b1; clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
        check("clr_valid", vld0, 0);
        check("clr_count", cnt0, 0);
        check("clr_sum", sum0, 0);
        check("clr_ready", rdy0, 1);
`ifdef AMA_ERR_MON_EN
        exp_err = 2;
`endif
        check("clr_err", err0, exp_err);
        repeat (3) @(negedge clk);
        check("clr_valid_later", vld0, 0);
        send_beat(24'h00003F, 1'b0);
        send_beat(24'h000001, 1'b1);
        wait_result();
        check("clr_next_sum", sum0, 32'h40);
        check("clr_next_count", cnt0, 2);
        handshake();

        // asynchronous reset mid-packet
        send_beat(24'h000011, 1'b0);
        in_valid = 1'b1; in_data = 24'h000022; in_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_err = 0;
        check("arst_count", cnt0, 0);
        check("arst_sum", sum0, 0);
        check("arst_valid", vld0, 0);
        check("arst_ready", rdy0, 1);
        check("arst_cout", cout0, 0);
        check("arst_err", err0, exp_err);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(24'h00003F, 1'b0);
        send_beat(24'h000001, 1'b1);
        wait_result();
        check("arst_next_sum", sum0, 32'h40);
        check("arst_next_count", cnt0, 2);
        handshake();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
